// File: rtl/spi_ram_master_ctrl.sv
// SPI master sequencer: expands byte RAM read/write requests into 10-bit SPI frames.
// Optional macro SPI_MASTER_ADDR_CACHE_EN skips repeated address frames.
module spi_ram_master_ctrl #(
    parameter int unsigned GAP_CYCLES     = 1,
    parameter int unsigned RD_WAIT        = 2,
    parameter int unsigned MISO_LSB_FIRST = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    if (GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_bad_gap
        $error("GAP_CYCLES must be in 1..15");
    end
    if (RD_WAIT > 15) begin : g_bad_rd_wait
        $error("RD_WAIT must be <= 15");
    end

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);
    localparam logic [3:0] RD_LAST  = 4'(RD_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_SHIFT,
        S_GAP,
        S_RD_WAIT,
        S_RX,
        S_DONE
    } state_t;

    state_t     state, state_nx;
    logic [3:0] cnt;
    logic       second;
    logic       is_write;
    logic [7:0] addr_q;
    logic [7:0] wdata_q;
    logic [7:0] rx_sr;
    logic [7:0] rx_nx;
    logic [7:0] payload;
    logic [9:0] frame;
    logic       cache_hit;

`ifdef SPI_MASTER_ADDR_CACHE_EN
    logic [7:0] wr_c_addr, rd_c_addr;
    logic       wr_c_vld, rd_c_vld;

    always_comb begin
        cache_hit = 1'b0;
        if (req_write) cache_hit = wr_c_vld && (wr_c_addr == req_addr);
        else           cache_hit = rd_c_vld && (rd_c_addr == req_addr);
    end

    // Cache is refreshed only once an address frame has fully shifted out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_c_addr <= '0;
            rd_c_addr <= '0;
            wr_c_vld  <= 1'b0;
            rd_c_vld  <= 1'b0;
        end else if (state == S_SHIFT && cnt == 4'd9 && !second) begin
            if (is_write) begin
                wr_c_addr <= addr_q;
                wr_c_vld  <= 1'b1;
            end else begin
                rd_c_addr <= addr_q;
                rd_c_vld  <= 1'b1;
            end
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    // Frame command is {read, second-frame}; payload is addr, wdata or dummy zero.
    always_comb begin
        payload = addr_q;
        if (second) payload = is_write ? wdata_q : 8'h00;
        frame = {~is_write, second, payload};
    end

    always_comb begin
        rx_nx = {rx_sr[6:0], MISO};
        if (MISO_LSB_FIRST != 0) rx_nx = {MISO, rx_sr[7:1]};
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (req_valid) state_nx = S_SEL;
            S_SEL:     state_nx = S_SHIFT;
            S_SHIFT: begin
                if (cnt == 4'd9) begin
                    if (second && !is_write) state_nx = (RD_WAIT == 0) ? S_RX : S_RD_WAIT;
                    else                     state_nx = S_GAP;
                end
            end
            S_GAP:     if (cnt == GAP_LAST) state_nx = second ? S_IDLE : S_SEL;
            S_RD_WAIT: if (cnt == RD_LAST) state_nx = S_RX;
            S_RX:      if (cnt == 4'd7) state_nx = S_DONE;
            S_DONE:    state_nx = S_GAP;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == S_IDLE);
        busy      = (state != S_IDLE);
        SS_n      = (state == S_IDLE) || (state == S_GAP);
        MOSI      = (state == S_SHIFT) ? frame[4'd9 - cnt] : 1'b0;
        rsp_valid = (state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            second    <= 1'b0;
            is_write  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rx_sr     <= '0;
            rsp_rdata <= '0;
        end else begin
            state <= state_nx;
            cnt   <= (state_nx != state) ? 4'd0 : cnt + 4'd1;
            if (state == S_IDLE && req_valid) begin
                is_write <= req_write;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                second   <= cache_hit;
            end
            if (state == S_GAP && state_nx == S_SEL) second <= 1'b1;
            // rsp_rdata is loaded on the last RX edge so it is valid during DONE.
            if (state == S_RX) begin
                rx_sr <= rx_nx;
                if (cnt == 4'd7) rsp_rdata <= rx_nx;
            end
        end
    end

endmodule

// File: tb/tb_spi_ram_master_ctrl.sv
// Directed bench for spi_ram_master_ctrl with a behavioural SPI-slave RAM model.
// Cache scenario runs only when SPI_MASTER_ADDR_CACHE_EN is defined.
module tb_spi_ram_master_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       busy;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;

    spi_ram_master_ctrl #(.GAP_CYCLES(1), .RD_WAIT(2), .MISO_LSB_FIRST(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
    );

    always #5 clk = ~clk;

    // Slave model: low-cycle index pos (0 = select cycle, 1..10 = frame bits).
    logic [7:0] ram [256];
    logic [7:0] waddr = '0, raddr = '0;
    logic [9:0] sh = '0;
    logic [9:0] frames [64];
    int         frame_cnt = 0;
    int         pos = 0;
    int         hi_run = 0;
    int         last_gap = 0;
    int         rsp_cnt = 0;
    logic [7:0] rd_byte;
    logic [2:0] bidx;

    assign rd_byte = ram[raddr];
    assign bidx    = 3'(pos - 14);
    assign MISO    = (pos >= 14 && pos <= 21) ? rd_byte[bidx] : 1'b0;

    always @(negedge clk) begin
        if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
        if (!SS_n) begin
            if (pos >= 1 && pos <= 10) sh <= {sh[8:0], MOSI};
            if (pos == 10) begin
                case (sh[8:7])
                    2'b00: waddr <= {sh[6:0], MOSI};
                    2'b01: ram[waddr] <= {sh[6:0], MOSI};
                    2'b10: raddr <= {sh[6:0], MOSI};
                    default: ;
                endcase
            end
            pos    <= pos + 1;
            hi_run <= 0;
            if (hi_run != 0) last_gap <= hi_run;
        end else begin
            if (pos >= 11) begin
                frames[frame_cnt] <= sh;
                frame_cnt <= frame_cnt + 1;
            end
            pos    <= 0;
            hi_run <= hi_run + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input logic w, input logic [7:0] a, input logic [7:0] d);
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int fb;
        int rb;
        int rdy_seen;

        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) tick();
        chk("rst_ss_n", SS_n, 1);
        chk("rst_mosi", MOSI, 0);
        chk("rst_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();

        // Write 0xFF <- 0xCF
        fb = frame_cnt; rb = rsp_cnt;
        start_req(1'b1, 8'hFF, 8'hCF);
        chk("wr_busy", busy, 1);
        chk("wr_ready_low", req_ready, 0);
        wait_idle(n);
        chk("wr_latency", n, 24);
        chk("wr_nframes", frame_cnt - fb, 2);
        chk("wr_frame0", frames[fb], 10'h0FF);
        chk("wr_frame1", frames[fb+1], 10'h1CF);
        chk("wr_gap", last_gap, 1);
        chk("wr_no_rsp", rsp_cnt - rb, 0);
        chk("wr_ready_back", req_ready, 1);

        // Read 0xFF, slave returns 0xCF
        fb = frame_cnt; rb = rsp_cnt;
        start_req(1'b0, 8'hFF, 8'h00);
        wait_idle(n);
        chk("rd_latency", n, 35);
        chk("rd_nframes", frame_cnt - fb, 2);
        chk("rd_frame0", frames[fb], 10'h2FF);
        chk("rd_frame1", frames[fb+1], 10'h300);
        chk("rd_rsp_pulses", rsp_cnt - rb, 1);
        chk("rd_rdata", rsp_rdata, 8'hCF);
        repeat (3) tick();
        chk("rd_rdata_held", rsp_rdata, 8'hCF);

        // Back-to-back: write 0x10 <- 0xA5 then read 0x10, both held valid
        fb = frame_cnt; rb = rsp_cnt;
        req_write = 1'b1; req_addr = 8'h10; req_wdata = 8'hA5; req_valid = 1'b1;
        tick();
        req_write = 1'b0; req_wdata = 8'h00;
        n = 0;
        while (!req_ready && n < 200) begin
            tick();
            n++;
        end
        chk("b2b_ready_at", n, 24);
        tick();
        req_valid = 1'b0;
        chk("b2b_second_busy", busy, 1);
        wait_idle(n);
        chk("b2b_rd_latency", n, 35);
        chk("b2b_nframes", frame_cnt - fb, 4);
        chk("b2b_frame0", frames[fb], 10'h010);
        chk("b2b_frame1", frames[fb+1], 10'h1A5);
        chk("b2b_frame2", frames[fb+2], 10'h210);
        chk("b2b_frame3", frames[fb+3], 10'h300);
        chk("b2b_rsp_pulses", rsp_cnt - rb, 1);
        chk("b2b_rdata", rsp_rdata, 8'hA5);

        // Reset during bit 5 of frame 0x1CF
        fb = frame_cnt; rb = rsp_cnt;
        start_req(1'b1, 8'hFF, 8'hCF);
        repeat (18) tick();
        chk("abort_pre_ss_n", SS_n, 0);
        rst_n = 1'b0;
        #1;
        chk("abort_ss_n", SS_n, 1);
        chk("abort_mosi", MOSI, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", req_ready, 1);
        chk("abort_rdata", rsp_rdata, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("abort_nframes", frame_cnt - fb, 1);
        chk("abort_frame0", frames[fb], 10'h0FF);
        chk("abort_no_rsp", rsp_cnt - rb, 0);
        fb = frame_cnt;
        start_req(1'b1, 8'h20, 8'h3C);
        wait_idle(n);
        chk("post_abort_latency", n, 24);
        chk("post_abort_frame0", frames[fb], 10'h020);
        chk("post_abort_frame1", frames[fb+1], 10'h13C);

        // req_valid toggled while busy
        fb = frame_cnt; rb = rsp_cnt;
        start_req(1'b1, 8'h55, 8'h66);
        rdy_seen = 0;
        for (int i = 0; i < 16; i++) begin
            req_valid = ((i % 2) == 0);
            req_write = 1'b0;
            req_addr  = 8'h77;
            tick();
            if (req_ready) rdy_seen++;
        end
        req_valid = 1'b0;
        chk("tog_ready_low", rdy_seen, 0);
        wait_idle(n);
        chk("tog_remaining", n, 8);
        chk("tog_nframes", frame_cnt - fb, 2);
        chk("tog_frame0", frames[fb], 10'h055);
        chk("tog_frame1", frames[fb+1], 10'h166);
        chk("tog_no_rsp", rsp_cnt - rb, 0);

`ifdef SPI_MASTER_ADDR_CACHE_EN
        fb = frame_cnt; rb = rsp_cnt;
        start_req(1'b1, 8'h40, 8'h11);
        wait_idle(n);
        chk("cache_wr1_latency", n, 24);
        chk("cache_wr1_frame0", frames[fb], 10'h040);
        chk("cache_wr1_frame1", frames[fb+1], 10'h111);
        fb = frame_cnt;
        start_req(1'b1, 8'h40, 8'h22);
        wait_idle(n);
        chk("cache_wr2_latency", n, 12);
        chk("cache_wr2_nframes", frame_cnt - fb, 1);
        chk("cache_wr2_frame", frames[fb], 10'h122);
        fb = frame_cnt;
        start_req(1'b0, 8'h40, 8'h00);
        wait_idle(n);
        chk("cache_rd_nframes", frame_cnt - fb, 2);
        chk("cache_rd_frame0", frames[fb], 10'h240);
        chk("cache_rd_frame1", frames[fb+1], 10'h300);
        chk("cache_rd_rdata", rsp_rdata, 8'h22);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
